axi_10g_ethernet_0_gt_reset_sequencer: RTL and testbench

AXI_10G_ETHERNET_0_GT_RESET_SEQUENCER -- requirements
Module: axi_10g_ethernet_0_gt_reset_sequencer

---
 rtl/axi_10g_ethernet_0_pkg.sv | 43 ++++
 rtl/axi_10g_ethernet_0_sync_block.sv | 21 ++
 rtl/axi_10g_ethernet_0_gt_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_axi_10g_ethernet_0_gt_reset_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axi_10g_ethernet_0_pkg.sv
// Shared definitions for the 10G Ethernet GT reset sequencer: state codes,
// default timeouts and the per-state output pattern.
package axi_10g_ethernet_0_pkg;

    localparam int DEFAULT_RST_PULSE_CYCLES = 32;
    localparam int DEFAULT_DONE_TIMEOUT     = 16384;
    localparam int DEFAULT_LOCK_TIMEOUT     = 1048576;

    typedef enum logic [2:0] {
        ST_WAIT_PLL  = 3'd0,
        ST_GT_RESET  = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RX   = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_RUN       = 3'd5,
        ST_RX_RESET  = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic gttxreset;
        logic gtrxreset;
        logic txuserrdy;
        logic rxuserrdy;
        logic tx_ready;
        logic rx_ready;
    } gt_ctrl_t;

    // Outputs are a pure function of the state being entered, so the FSM
    // loads them together with the state register.
    function automatic gt_ctrl_t ctrl_for(input seq_state_t s);
        gt_ctrl_t c;
        case (s)
            ST_WAIT_TX:   c = gt_ctrl_t'(6'b001000);
            ST_WAIT_RX:   c = gt_ctrl_t'(6'b001110);
            ST_WAIT_LOCK: c = gt_ctrl_t'(6'b001110);
            ST_RUN:       c = gt_ctrl_t'(6'b001111);
            ST_RX_RESET:  c = gt_ctrl_t'(6'b011010);
            default:      c = gt_ctrl_t'(6'b110000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_sync_block.sv
// Two-flop synchroniser bringing an asynchronous level into the coreclk domain.
module axi_10g_ethernet_0_sync_block (
    input  logic clk,
    input  logic reset,
    input  logic data,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= data;
            synced <= meta;
        end
    end

endmodule

// File: rtl/axi_10g_ethernet_0_gt_reset_sequencer.sv
// GT reset sequencer: waits for QPLL lock, pulses the GT resets, then walks
// TX done, RX done and block lock with timeouts and retries.
module axi_10g_ethernet_0_gt_reset_sequencer
    import axi_10g_ethernet_0_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = DEFAULT_RST_PULSE_CYCLES,
    parameter int DONE_TIMEOUT     = DEFAULT_DONE_TIMEOUT,
    parameter int LOCK_TIMEOUT     = DEFAULT_LOCK_TIMEOUT
) (
    input  logic       coreclk,
    input  logic       reset,
    input  logic       qplllock,
    input  logic       reset_counter_done,
    input  logic       txresetdone,
    input  logic       rxresetdone,
    input  logic       rx_block_lock,
    output logic       gttxreset,
    output logic       gtrxreset,
    output logic       txuserrdy,
    output logic       rxuserrdy,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic [2:0] seq_state,
    output logic [7:0] restart_count
);

    localparam int MAX_A      = (RST_PULSE_CYCLES > DONE_TIMEOUT) ? RST_PULSE_CYCLES : DONE_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    logic qplllock_sync;
    logic txresetdone_sync;
    logic rxresetdone_sync;
    logic rx_block_lock_sync;

    axi_10g_ethernet_0_sync_block u_sync_qplllock (
        .clk(coreclk), .reset(reset), .data(qplllock), .synced(qplllock_sync)
    );
    axi_10g_ethernet_0_sync_block u_sync_txresetdone (
        .clk(coreclk), .reset(reset), .data(txresetdone), .synced(txresetdone_sync)
    );
    axi_10g_ethernet_0_sync_block u_sync_rxresetdone (
        .clk(coreclk), .reset(reset), .data(rxresetdone), .synced(rxresetdone_sync)
    );
    axi_10g_ethernet_0_sync_block u_sync_rx_block_lock (
        .clk(coreclk), .reset(reset), .data(rx_block_lock), .synced(rx_block_lock_sync)
    );

    seq_state_t       state;
    gt_ctrl_t         ctrl;
    logic [CNT_W-1:0] counter;
    logic [7:0]       restarts;

    // Every transition reloads state, outputs and clears the shared counter;
    // the counter stops at each state's last cycle so it can never wrap.
    always_ff @(posedge coreclk) begin
        if (reset) begin
            state    <= ST_WAIT_PLL;
            ctrl     <= ctrl_for(ST_WAIT_PLL);
            counter  <= '0;
            restarts <= '0;
        end else if (state != ST_WAIT_PLL && !qplllock_sync) begin
            state   <= ST_WAIT_PLL;
            ctrl    <= ctrl_for(ST_WAIT_PLL);
            counter <= '0;
        end else begin
            case (state)
                ST_WAIT_PLL: begin
                    counter <= '0;
                    if (qplllock_sync && reset_counter_done) begin
                        state <= ST_GT_RESET;
                        ctrl  <= ctrl_for(ST_GT_RESET);
                    end
                end
                ST_GT_RESET: begin
                    if (counter == PULSE_LAST) begin
                        state   <= ST_WAIT_TX;
                        ctrl    <= ctrl_for(ST_WAIT_TX);
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_WAIT_TX: begin
                    if (txresetdone_sync) begin
                        state   <= ST_WAIT_RX;
                        ctrl    <= ctrl_for(ST_WAIT_RX);
                        counter <= '0;
                    end else if (counter == DONE_LAST) begin
                        state    <= ST_GT_RESET;
                        ctrl     <= ctrl_for(ST_GT_RESET);
                        counter  <= '0;
                        restarts <= (restarts == 8'hFF) ? restarts : restarts + 8'd1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_WAIT_RX: begin
                    if (rxresetdone_sync) begin
                        state   <= ST_WAIT_LOCK;
                        ctrl    <= ctrl_for(ST_WAIT_LOCK);
                        counter <= '0;
                    end else if (counter == DONE_LAST) begin
                        state    <= ST_RX_RESET;
                        ctrl     <= ctrl_for(ST_RX_RESET);
                        counter  <= '0;
                        restarts <= (restarts == 8'hFF) ? restarts : restarts + 8'd1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (rx_block_lock_sync) begin
                        state   <= ST_RUN;
                        ctrl    <= ctrl_for(ST_RUN);
                        counter <= '0;
                    end else if (counter == LOCK_LAST) begin
                        state    <= ST_RX_RESET;
                        ctrl     <= ctrl_for(ST_RX_RESET);
                        counter  <= '0;
                        restarts <= (restarts == 8'hFF) ? restarts : restarts + 8'd1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    counter <= '0;
                    if (!rx_block_lock_sync) begin
                        state <= ST_WAIT_LOCK;
                        ctrl  <= ctrl_for(ST_WAIT_LOCK);
                    end
                end
                ST_RX_RESET: begin
                    if (counter == PULSE_LAST) begin
                        state   <= ST_WAIT_RX;
                        ctrl    <= ctrl_for(ST_WAIT_RX);
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_WAIT_PLL;
                    ctrl    <= ctrl_for(ST_WAIT_PLL);
                    counter <= '0;
                end
            endcase
        end
    end

    assign gttxreset     = ctrl.gttxreset;
    assign gtrxreset     = ctrl.gtrxreset;
    assign txuserrdy     = ctrl.txuserrdy;
    assign rxuserrdy     = ctrl.rxuserrdy;
    assign tx_ready      = ctrl.tx_ready;
    assign rx_ready      = ctrl.rx_ready;
    assign seq_state     = state;
    assign restart_count = restarts;

endmodule

// File: tb/tb_axi_10g_ethernet_0_gt_reset_sequencer.sv
// Directed bench for the GT reset sequencer with short pulse and timeout values.
module tb_axi_10g_ethernet_0_gt_reset_sequencer;

    logic       coreclk;
    logic       reset;
    logic       qplllock;
    logic       reset_counter_done;
    logic       txresetdone;
    logic       rxresetdone;
    logic       rx_block_lock;
    logic       gttxreset;
    logic       gtrxreset;
    logic       txuserrdy;
    logic       rxuserrdy;
    logic       tx_ready;
    logic       rx_ready;
    logic [2:0] seq_state;
    logic [7:0] restart_count;

    int checks_total = 0;
    int checks_passed = 0;

    axi_10g_ethernet_0_gt_reset_sequencer #(
        .RST_PULSE_CYCLES(4),
        .DONE_TIMEOUT(100),
        .LOCK_TIMEOUT(200)
    ) dut (
        .coreclk(coreclk),
        .reset(reset),
        .qplllock(qplllock),
        .reset_counter_done(reset_counter_done),
        .txresetdone(txresetdone),
        .rxresetdone(rxresetdone),
        .rx_block_lock(rx_block_lock),
        .gttxreset(gttxreset),
        .gtrxreset(gtrxreset),
        .txuserrdy(txuserrdy),
        .rxuserrdy(rxuserrdy),
        .tx_ready(tx_ready),
        .rx_ready(rx_ready),
        .seq_state(seq_state),
        .restart_count(restart_count)
    );

    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;

    task automatic stepClock();
        @(posedge coreclk);
        #1;
    endtask

    task automatic applyStimulus(input logic pll, input logic cnt_done,
                                 input logic txd, input logic rxd, input logic lock);
        qplllock           = pll;
        reset_counter_done = cnt_done;
        txresetdone        = txd;
        rxresetdone        = rxd;
        rx_block_lock      = lock;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int ctrl_bits();
        return int'({gttxreset, gtrxreset, txuserrdy, rxuserrdy, tx_ready, rx_ready});
    endfunction

    task automatic waitState(input int target, input int budget, input string tag);
        int n = 0;
        while (int'(seq_state) != target && n < budget) begin
            stepClock();
            n++;
        end
        checkOutput(tag, int'(seq_state), target);
    endtask

    initial begin
        int high_cycles;
        int first_lock;
        int lock_run;
        int rxreset_high;
        int tx_bad;
        int rx_bad;
        bit left_first;

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) stepClock();
        checkOutput("reset_ctrl", ctrl_bits(), 6'b110000);
        checkOutput("reset_state", int'(seq_state), 0);
        checkOutput("reset_restarts", int'(restart_count), 0);
        reset = 1'b0;

        // Nominal bring-up
        applyStimulus(1, 1, 0, 0, 0);
        waitState(1, 10, "enter_gt_reset");
        high_cycles = 0;
        for (int n = 0; n < 20 && seq_state == 3'd1; n++) begin
            if (gttxreset) high_cycles++;
            stepClock();
        end
        checkOutput("gttxreset_pulse_len", high_cycles, 4);
        checkOutput("wait_tx_state", int'(seq_state), 2);
        checkOutput("wait_tx_ctrl", ctrl_bits(), 6'b001000);
        repeat (10) stepClock();
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3, 10, "enter_wait_rx");
        checkOutput("wait_rx_ctrl", ctrl_bits(), 6'b001110);
        repeat (10) stepClock();
        applyStimulus(1, 1, 1, 1, 0);
        waitState(4, 10, "enter_wait_lock");
        repeat (20) stepClock();
        applyStimulus(1, 1, 1, 1, 1);
        waitState(5, 10, "enter_run");
        checkOutput("run_ctrl", ctrl_bits(), 6'b001111);
        checkOutput("run_restarts", int'(restart_count), 0);

        // Block lock lost for 250 cycles
        applyStimulus(1, 1, 1, 1, 0);
        first_lock = 0; lock_run = 0; rxreset_high = 0; tx_bad = 0; rx_bad = 0;
        left_first = 1'b0;
        for (int i = 1; i <= 250; i++) begin
            stepClock();
            if (seq_state == 3'd4 && first_lock == 0) first_lock = i;
            if (seq_state == 3'd4 && !left_first) lock_run++;
            if (seq_state == 3'd6) begin
                left_first = 1'b1;
                if (gtrxreset) rxreset_high++;
                if (rxuserrdy || rx_ready) rx_bad++;
            end
            if (seq_state == 3'd4 && rx_ready) rx_bad++;
            if (gttxreset || !tx_ready) tx_bad++;
        end
        checkOutput("lockloss_latency", first_lock, 3);
        checkOutput("lock_timeout_len", lock_run, 200);
        checkOutput("rx_reset_pulse_len", rxreset_high, 4);
        checkOutput("tx_untouched", tx_bad, 0);
        checkOutput("rx_outputs_low", rx_bad, 0);
        checkOutput("lock_restarts", int'(restart_count), 1);
        applyStimulus(1, 1, 1, 1, 1);
        waitState(5, 10, "relock_run");

        // QPLL lock lost while running
        applyStimulus(0, 1, 1, 1, 1);
        repeat (2) stepClock();
        checkOutput("pll_loss_not_yet", int'(seq_state), 5);
        stepClock();
        checkOutput("pll_loss_state", int'(seq_state), 0);
        checkOutput("pll_loss_ctrl", ctrl_bits(), 6'b110000);
        checkOutput("pll_loss_restarts", int'(restart_count), 1);

        // rxresetdone arrives on the same cycle as the WAIT_RX timeout
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3, 30, "sim_enter_wait_rx");
        repeat (97) stepClock();
        applyStimulus(1, 1, 1, 1, 0);
        repeat (2) stepClock();
        checkOutput("sim_still_wait_rx", int'(seq_state), 3);
        stepClock();
        checkOutput("sim_done_wins", int'(seq_state), 4);
        checkOutput("sim_restarts", int'(restart_count), 1);

        // One-cycle reset while in WAIT_LOCK
        reset = 1'b1;
        stepClock();
        checkOutput("midreset_ctrl", ctrl_bits(), 6'b110000);
        checkOutput("midreset_state", int'(seq_state), 0);
        checkOutput("midreset_restarts", int'(restart_count), 0);
        reset = 1'b0;

        // TX done never arrives: retries and saturation
        applyStimulus(1, 1, 0, 0, 0);
        waitState(2, 30, "txto_enter_wait_tx");
        repeat (99) stepClock();
        checkOutput("txto_still_wait_tx", int'(seq_state), 2);
        stepClock();
        checkOutput("txto_back_gt_reset", int'(seq_state), 1);
        checkOutput("txto_restarts_1", int'(restart_count), 1);
        repeat (300 * 104) stepClock();
        checkOutput("txto_saturated", int'(restart_count), 255);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
